// File: rtl/round_key_store_pkg.sv
// Shared widths, FSM states and stream-order helpers for the round key store.
package round_key_store_pkg;

  localparam int KEY_S  = 128;  // round key width in bits
  localparam int NR     = 10;   // number of rounds; NR+1 keys are stored
  localparam int ADDR_W = 4;    // round key address/index width

  typedef logic [ADDR_W-1:0] idx_t;
  typedef logic [0:KEY_S-1]  key_t;  // bit 0 is the MSB

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam idx_t IDX_MAX   = idx_t'(NR);
  localparam idx_t IDX_STEP  = idx_t'(1);

  // Forward order runs 0..NR (encrypt), reverse runs NR..0 (decrypt).
  localparam idx_t FWD_START = '0;
  localparam idx_t FWD_END   = IDX_MAX;
  localparam idx_t REV_START = IDX_MAX;
  localparam idx_t REV_END   = '0;

  function automatic idx_t first_idx(input logic dir);
    return dir ? REV_START : FWD_START;
  endfunction

  function automatic idx_t last_idx(input logic dir);
    return dir ? REV_END : FWD_END;
  endfunction

  function automatic idx_t step_idx(input logic dir, input idx_t idx);
    return dir ? (idx - IDX_STEP) : (idx + IDX_STEP);
  endfunction

endpackage

// File: rtl/round_key_store_rf.sv
// NR+1 x KEY_S round key register file with written mask and keys_valid flag.
module round_key_rf
  import round_key_store_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_we,
  input  idx_t i_waddr,
  input  key_t i_wdata,
  input  idx_t i_raddr,
  output key_t o_rdata,
  output logic o_keys_valid
);

  key_t        r_mem [0:NR];
  logic [NR:0] r_mask;
  logic        r_keys_valid;
  logic        w_wr_ok;
  logic [NR:0] w_mask_next;

  // Writes beyond the last round key are dropped entirely.
  assign w_wr_ok = i_we && (i_waddr <= IDX_MAX);

  // Next written mask: a write to key 0 restarts the schedule.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_mask_next = r_mask;
    if (w_wr_ok) begin
      if (i_waddr == '0) w_mask_next = {{NR{1'b0}}, 1'b1};
      else               w_mask_next[i_waddr] = 1'b1;
    end
  end

  // Key storage, written mask and registered completeness flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the key storage is cleared on reset because stale keys must never reach the datapath.
      for (int i = 0; i <= NR; i++) r_mem[i] <= '0;
      r_mask       <= '0;
      r_keys_valid <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so all registers sample the same pre-edge values.
      if (w_wr_ok) r_mem[i_waddr] <= i_wdata;
      r_mask       <= w_mask_next;
      r_keys_valid <= &w_mask_next;
    end
  end

  // Read port with write-through: a key loaded in the cycle it is rewritten gets the new value.
  always_comb begin
    o_rdata = '0;
    if (w_wr_ok && (i_waddr == i_raddr)) o_rdata = i_wdata;
    else if (i_raddr <= IDX_MAX)         o_rdata = r_mem[i_raddr];
  end

  assign o_keys_valid = r_keys_valid;

endmodule

// File: rtl/round_key_store.sv
// Captures the expanded round keys and streams them forward or reverse over valid/ready.
module round_key_store
  import round_key_store_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              w_e,
  input  logic [0:ADDR_W-1] round_key_addr,
  input  logic [0:KEY_S-1]  round_key,
  input  logic              start,
  input  logic              decrypt,
  input  logic              rk_ready,
  output logic              rk_valid,
  output logic [0:KEY_S-1]  rk_data,
  output logic [0:ADDR_W-1] rk_idx,
  output logic              rk_last,
  output logic              keys_valid,
  output logic              busy,
  output logic              done,
  output logic              abort
);

  state_t r_state;
  logic   r_dir;
  logic   r_rk_valid;
  key_t   r_rk_data;
  idx_t   r_rk_idx;
  logic   r_rk_last;
  logic   r_busy;
  logic   r_done;
  logic   r_abort;

  idx_t   w_wr_addr;
  idx_t   w_rd_addr;
  idx_t   w_next_idx;
  key_t   w_rd_data;
  logic   w_keys_valid;
  logic   w_restart;

  assign w_wr_addr  = round_key_addr;
  assign w_restart  = w_e && (w_wr_addr == '0);
  assign w_next_idx = step_idx(r_dir, r_rk_idx);

  // Read address: the first key of the requested order while idle, otherwise the next key.
  always_comb begin
    w_rd_addr = w_next_idx;
    if (r_state == IDLE) w_rd_addr = first_idx(decrypt);
  end

  round_key_rf u_rf (
    .clk          (clk),
    .reset        (reset),
    .i_we         (w_e),
    .i_waddr      (w_wr_addr),
    .i_wdata      (round_key),
    .i_raddr      (w_rd_addr),
    .o_rdata      (w_rd_data),
    .o_keys_valid (w_keys_valid)
  );

  // Stream control: sequences keys and owns every registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_dir      <= 1'b0;
      r_rk_valid <= 1'b0;
      r_rk_data  <= '0;
      r_rk_idx   <= '0;
      r_rk_last  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && w_keys_valid) begin
            r_state    <= STREAM;
            r_dir      <= decrypt;
            r_rk_valid <= 1'b1;
            r_rk_idx   <= first_idx(decrypt);
            r_rk_data  <= w_rd_data;
            r_rk_last  <= (first_idx(decrypt) == last_idx(decrypt));
            r_busy     <= 1'b1;
          end
        end
        STREAM: begin
          if (w_restart) begin
            // Schedule restart kills the stream; a same-cycle handshake is discarded.
            r_state    <= IDLE;
            r_rk_valid <= 1'b0;
            r_rk_data  <= '0;
            r_rk_idx   <= '0;
            r_rk_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_abort    <= 1'b1;
          end else if (rk_ready) begin
            if (r_rk_last) begin
              r_state    <= DONE;
              r_rk_valid <= 1'b0;
              r_rk_data  <= '0;
              r_rk_idx   <= '0;
              r_rk_last  <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_rk_idx   <= w_next_idx;
              r_rk_data  <= w_rd_data;
              r_rk_last  <= (w_next_idx == last_idx(r_dir));
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rk_valid   = r_rk_valid;
  assign rk_data    = r_rk_data;
  assign rk_idx     = r_rk_idx;
  assign rk_last    = r_rk_last;
  assign keys_valid = w_keys_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign abort      = r_abort;

endmodule

// File: tb/tb_round_key_store.sv
// Self-checking bench for round_key_store: directed schedule tests plus randomized streams.
module tb_round_key_store;

  localparam int NR  = 10;
  localparam int MAX_CYC = 200;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         w_e = 1'b0;
  logic [0:3]   round_key_addr = '0;
  logic [0:127] round_key = '0;
  logic         start = 1'b0;
  logic         decrypt = 1'b0;
  logic         rk_ready = 1'b0;
  logic         rk_valid;
  logic [0:127] rk_data;
  logic [0:3]   rk_idx;
  logic         rk_last;
  logic         keys_valid;
  logic         busy;
  logic         done;
  logic         abort;

  // Reference model: key contents and which keys were written since the last restart.
  logic [127:0] m_mem [0:NR];
  logic [NR:0]  m_mask;
  logic [127:0] kf [0:NR];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  round_key_store dut (
    .clk            (clk),
    .reset          (reset),
    .w_e            (w_e),
    .round_key_addr (round_key_addr),
    .round_key      (round_key),
    .start          (start),
    .decrypt        (decrypt),
    .rk_ready       (rk_ready),
    .rk_valid       (rk_valid),
    .rk_data        (rk_data),
    .rk_idx         (rk_idx),
    .rk_last        (rk_last),
    .keys_valid     (keys_valid),
    .busy           (busy),
    .done           (done),
    .abort          (abort)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: inputs set before the call are sampled at the edge; outputs read 1 time unit after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i <= NR; i++) m_mem[i] = '0;
    m_mask = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 128'(rk_valid), 128'(0));
    check({tag, "_data"},  128'(rk_data),  128'(0));
    check({tag, "_idx"},   128'(rk_idx),   128'(0));
    check({tag, "_last"},  128'(rk_last),  128'(0));
    check({tag, "_busy"},  128'(busy),     128'(0));
  endtask

  task automatic write_key(input int addr, input logic [127:0] data);
    w_e = 1'b1;
    round_key_addr = addr[3:0];
    round_key = data;
    step();
    w_e = 1'b0;
    if (addr <= NR) begin
      m_mem[addr] = data;
      if (addr == 0) m_mask = {{NR{1'b0}}, 1'b1};
      else           m_mask[addr] = 1'b1;
    end
    check("keys_valid_after_write", 128'(keys_valid), 128'(&m_mask));
  endtask

  // Runs one whole stream against the expected key order; optionally rewrites key wa mid-stream.
  task automatic run_stream(input logic dir, input int mode, input int wa, output int cycles);
    int q[$];
    logic rdy;
    logic wrote;
    logic [127:0] wd;
    int cyc;
    for (int k = 0; k <= NR; k++) q.push_back(dir ? NR - k : k);
    start = 1'b1;
    decrypt = dir;
    step();
    start = 1'b0;
    cyc = 0;
    while (q.size() > 0 && cyc < MAX_CYC) begin
      check("stream_valid", 128'(rk_valid), 128'(1));
      check("stream_idx",   128'(rk_idx),   128'(q[0]));
      check("stream_data",  128'(rk_data),  m_mem[q[0]]);
      check("stream_last",  128'(rk_last),  128'(q.size() == 1));
      check("stream_busy",  128'(busy),     128'(1));
      check("stream_done",  128'(done),     128'(0));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rk_ready = rdy;
      start = 1'($urandom_range(0, 1));
      decrypt = 1'($urandom_range(0, 1));
      wrote = 1'b0;
      wd = '0;
      if (cyc == 1 && wa > 0 && wa != q[0]) begin
        wd = {$urandom, $urandom, $urandom, $urandom};
        w_e = 1'b1;
        round_key_addr = wa[3:0];
        round_key = wd;
        wrote = 1'b1;
      end
      step();
      w_e = 1'b0;
      if (wrote && wa <= NR) m_mem[wa] = wd;
      if (rdy) void'(q.pop_front());
      cyc++;
    end
    if (q.size() != 0) check("stream_timeout_keys_left", 128'(q.size()), 128'(0));
    cycles = cyc;
    rk_ready = 1'b0;
    start = 1'b1;  // must be ignored in DONE
    check("after_last_valid", 128'(rk_valid), 128'(0));
    check("after_last_data",  128'(rk_data),  128'(0));
    check("after_last_done",  128'(done),     128'(1));
    check("after_last_busy",  128'(busy),     128'(1));
    step();
    start = 1'b0;
    check("done_pulse_end", 128'(done), 128'(0));
    check_idle_outputs("back_to_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int perm [10];
    int tmp;
    int j;
    kf[0]  = 128'h5468617473206d79204b756e67204675;
    kf[1]  = 128'he232fcf191129188b159e4e6d679a293;
    kf[2]  = 128'h56082007c71ab18f76435569a03af7fa;
    kf[3]  = 128'hd2600de7157abc686339e901c3031efb;
    kf[4]  = 128'ha11202c9b468bea1d75157a01452495b;
    kf[5]  = 128'hb1293b3305418592d210d232c6429b69;
    kf[6]  = 128'hbd3dc287b87c47156a6c9527ac2e0e4e;
    kf[7]  = 128'hcc96ed1674eaaa031e863f24b2a8316a;
    kf[8]  = 128'h8e51ef21fabb4522e43d7a0656954b6c;
    kf[9]  = 128'hbfe2bf904559fab2a16480b4f7f1cbd8;
    kf[10] = 128'h28fddef86da4244accc0a4fe3b316f26;
    model_clear();

    // Reset state
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_idle_outputs("reset");
    check("reset_keys_valid", 128'(keys_valid), 128'(0));
    check("reset_done",       128'(done),       128'(0));
    check("reset_abort",      128'(abort),      128'(0));

    // 1: full schedule, forward, always ready -> 11 back-to-back keys
    for (int a = 0; a <= NR; a++) write_key(a, kf[a]);
    run_stream(1'b0, 0, 0, cyc);
    check("fwd_full_rate_cycles", 128'(cyc), 128'(NR + 1));

    // 2: reverse order
    run_stream(1'b1, 0, 0, cyc);
    check("rev_full_rate_cycles", 128'(cyc), 128'(NR + 1));

    // 3: forward with ready pattern 1,0,0,...
    run_stream(1'b0, 1, 0, cyc);
    check("stall_stream_cycles", 128'(cyc), 128'(3 * NR + 1));

    // 4: incomplete schedule ignores start; out-of-range write ignored; last key completes
    for (int a = 0; a < NR; a++) write_key(a, kf[a]);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_idle_outputs("start_without_keys");
    write_key(15, 128'hdeadbeef);
    write_key(10, kf[10]);

    // 5: abort after 3 accepted keys; same-cycle handshake is discarded
    start = 1'b1;
    decrypt = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("abort_pre_idx", 128'(rk_idx), 128'(k));
      rk_ready = 1'b1;
      step();
    end
    check("abort_pre_idx3", 128'(rk_idx), 128'(3));
    w_e = 1'b1;
    round_key_addr = 4'd0;
    round_key = kf[0];
    step();
    w_e = 1'b0;
    rk_ready = 1'b0;
    m_mem[0] = kf[0];
    m_mask = {{NR{1'b0}}, 1'b1};
    check_idle_outputs("abort");
    check("abort_pulse",      128'(abort),      128'(1));
    check("abort_keys_valid", 128'(keys_valid), 128'(0));
    check("abort_no_done",    128'(done),       128'(0));
    step();
    check("abort_pulse_end", 128'(abort), 128'(0));
    check("abort_no_done2",  128'(done),  128'(0));
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_idle_outputs("start_after_abort");
    for (int a = 1; a <= NR; a++) write_key(a, kf[a]);

    // 6: reset while the 5th key is presented
    start = 1'b1;
    decrypt = 1'b0;
    step();
    start = 1'b0;
    rk_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("reset_mid_idx", 128'(rk_idx), 128'(4));
    reset = 1'b1;
    step();
    reset = 1'b0;
    rk_ready = 1'b0;
    model_clear();
    check_idle_outputs("reset_mid");
    check("reset_mid_keys_valid", 128'(keys_valid), 128'(0));
    check("reset_mid_done",       128'(done),       128'(0));
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_idle_outputs("start_after_reset");

    // Randomized schedules (random write order, stray writes) and randomized streams
    for (int r = 0; r < 12; r++) begin
      write_key(0, {$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < 10; i++) perm[i] = i + 1;
      for (int i = 9; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = perm[i];
        perm[i] = perm[j];
        perm[j] = tmp;
      end
      for (int i = 0; i < 10; i++) begin
        if ($urandom_range(0, 3) == 0)
          write_key($urandom_range(NR + 1, 15), {$urandom, $urandom, $urandom, $urandom});
        if (i == 9) begin
          start = 1'b1;
          decrypt = 1'($urandom_range(0, 1));
          step();
          start = 1'b0;
          check_idle_outputs("rand_start_incomplete");
        end
        write_key(perm[i], {$urandom, $urandom, $urandom, $urandom});
      end
      run_stream(1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(1, 15), cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
